trip_odometer: RTL and testbench

Parametrised successor to the single-counter distance block in the bike-computer datapath. It conditions the raw reed-switch input (synchronise, debounce, edge-detect) and turns each wheel revolution into a circumference increment. It keeps two distance registers: a clearable trip counter and a lifetime total counter. Configurable overflow policy (saturate or wrap) with sticky overflow flags; outputs feed the display/mode controller.

---
 rtl/trip_odometer.sv | 155 +++++++++++++++
 tb/tb_trip_odometer.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trip_odometer.sv
// trip_odometer: reed-switch conditioning (synchronise, debounce, edge-detect)
// feeding two distance counters, a clearable trip counter and a lifetime
// total counter. Each counter carries a centimetre remainder so wheel
// circumferences that are not a multiple of the distance unit add up exactly.
module trip_odometer #(
    parameter int CIRC_W   = 8,
    parameter int DIST_W   = 14,
    parameter int UNIT_CM  = 10000,
    parameter int DEBOUNCE = 1,
    parameter int SATURATE = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              reed,
    input  logic [CIRC_W-1:0] circ,
    input  logic              trip_clear,
    output logic [DIST_W-1:0] distance_trip,
    output logic [DIST_W-1:0] distance_total,
    output logic              trip_ovf,
    output logic              total_ovf,
    output logic              rev_pulse
);

    // The remainder plus one circumference must fit without wrapping.
    localparam int ACC_W = $clog2(UNIT_CM + 2**CIRC_W);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    localparam logic [ACC_W-1:0]  UNIT  = ACC_W'(UNIT_CM);
    localparam logic [CNT_W-1:0]  DEB_N = CNT_W'(DEBOUNCE);
    localparam logic [DIST_W-1:0] DMAX  = '1;

    logic             sync1;
    logic             sync2;
    logic             deb;
    logic             deb_nx;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] deb_cnt_nx;
    logic [CNT_W-1:0] deb_cnt_inc;
    logic             rev;

    logic [ACC_W-1:0]  circ_ext;
    logic [ACC_W-1:0]  acc_trip;
    logic [ACC_W-1:0]  acc_total;
    logic [ACC_W-1:0]  sum_trip;
    logic [ACC_W-1:0]  sum_total;
    logic [ACC_W-1:0]  acc_trip_nx;
    logic [ACC_W-1:0]  acc_total_nx;
    logic [DIST_W-1:0] dist_trip_nx;
    logic [DIST_W-1:0] dist_total_nx;
    logic              trip_ovf_nx;
    logic              total_ovf_nx;

    assign circ_ext    = ACC_W'(circ);
    assign deb_cnt_inc = deb_cnt + CNT_W'(1);

    // Two-flop synchroniser for the asynchronous reed level.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= reed;
            sync2 <= sync1;
        end
    end

    // Debounce: a level change is accepted once it has been seen on DEBOUNCE
    // consecutive samples; any agreeing sample restarts the count.
    always_comb begin
        deb_nx     = deb;
        deb_cnt_nx = '0;
        if (sync2 != deb) begin
            if (deb_cnt_inc == DEB_N) begin
                deb_nx = ~deb;
            end else begin
                deb_cnt_nx = deb_cnt_inc;
            end
        end
        rev = deb_nx & ~deb;
    end

    // Debounced level, its counter and the registered revolution pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            deb       <= 1'b0;
            deb_cnt   <= '0;
            rev_pulse <= 1'b0;
        end else begin
            deb       <= deb_nx;
            deb_cnt   <= deb_cnt_nx;
            rev_pulse <= rev;
        end
    end

    // Trip counter next state: add one circumference, carry at most one unit.
    always_comb begin
        sum_trip     = acc_trip + circ_ext;
        acc_trip_nx  = sum_trip;
        dist_trip_nx = distance_trip;
        trip_ovf_nx  = trip_ovf;
        if (sum_trip >= UNIT) begin
            acc_trip_nx = sum_trip - UNIT;
            if (distance_trip == DMAX) begin
                trip_ovf_nx  = 1'b1;
                dist_trip_nx = (SATURATE != 0) ? DMAX : '0;
            end else begin
                dist_trip_nx = distance_trip + DIST_W'(1);
            end
        end
    end

    // Total counter next state: same arithmetic as the trip counter.
    always_comb begin
        sum_total     = acc_total + circ_ext;
        acc_total_nx  = sum_total;
        dist_total_nx = distance_total;
        total_ovf_nx  = total_ovf;
        if (sum_total >= UNIT) begin
            acc_total_nx = sum_total - UNIT;
            if (distance_total == DMAX) begin
                total_ovf_nx  = 1'b1;
                dist_total_nx = (SATURATE != 0) ? DMAX : '0;
            end else begin
                dist_total_nx = distance_total + DIST_W'(1);
            end
        end
    end

    // Trip registers: clear has priority over a coincident revolution.
    always_ff @(posedge clock) begin
        if (reset || trip_clear) begin
            acc_trip      <= '0;
            distance_trip <= '0;
            trip_ovf      <= 1'b0;
        end else if (rev_pulse) begin
            acc_trip      <= acc_trip_nx;
            distance_trip <= dist_trip_nx;
            trip_ovf      <= trip_ovf_nx;
        end
    end

    // Total registers: only reset clears them.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_total      <= '0;
            distance_total <= '0;
            total_ovf      <= 1'b0;
        end else if (rev_pulse) begin
            acc_total      <= acc_total_nx;
            distance_total <= dist_total_nx;
            total_ovf      <= total_ovf_nx;
        end
    end

endmodule

// File: tb/tb_trip_odometer.sv
// Bench for trip_odometer: default instance, a DEBOUNCE=4 instance and a
// small-counter pair (saturate / wrap) driven with identical stimulus.
module tb_trip_odometer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    logic        reed_a, clr_a;
    logic [7:0]  circ_a;
    logic [13:0] dt_a, dT_a;
    logic        tovf_a, Tovf_a, rp_a;

    logic        reed_b, clr_b;
    logic [7:0]  circ_b;
    logic [13:0] dt_b, dT_b;
    logic        tovf_b, Tovf_b, rp_b;

    logic        reed_c, clr_c;
    logic [7:0]  circ_c;
    logic [3:0]  dt_s, dT_s, dt_w, dT_w;
    logic        tovf_s, Tovf_s, rp_s, tovf_w, Tovf_w, rp_w;

    trip_odometer u0 (
        .clock(clock), .reset(reset), .reed(reed_a), .circ(circ_a), .trip_clear(clr_a),
        .distance_trip(dt_a), .distance_total(dT_a), .trip_ovf(tovf_a), .total_ovf(Tovf_a),
        .rev_pulse(rp_a));

    trip_odometer #(.DEBOUNCE(4)) u_db (
        .clock(clock), .reset(reset), .reed(reed_b), .circ(circ_b), .trip_clear(clr_b),
        .distance_trip(dt_b), .distance_total(dT_b), .trip_ovf(tovf_b), .total_ovf(Tovf_b),
        .rev_pulse(rp_b));

    trip_odometer #(.DIST_W(4), .UNIT_CM(200), .SATURATE(1)) u_sat (
        .clock(clock), .reset(reset), .reed(reed_c), .circ(circ_c), .trip_clear(clr_c),
        .distance_trip(dt_s), .distance_total(dT_s), .trip_ovf(tovf_s), .total_ovf(Tovf_s),
        .rev_pulse(rp_s));

    trip_odometer #(.DIST_W(4), .UNIT_CM(200), .SATURATE(0)) u_wrap (
        .clock(clock), .reset(reset), .reed(reed_c), .circ(circ_c), .trip_clear(clr_c),
        .distance_trip(dt_w), .distance_total(dT_w), .trip_ovf(tovf_w), .total_ovf(Tovf_w),
        .rev_pulse(rp_w));

    int total = 0;
    int bad   = 0;

    // Reference model: 0 = u0, 1 = u_sat, 2 = u_wrap.
    typedef struct {
        int trip;
        int tot;
        int tovf;
        int Tovf;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int m_unit[3] = '{10000, 200, 200};
    int m_dmax[3] = '{16383, 15, 15};
    int m_sat[3]  = '{1, 1, 0};
    int m_acct[3], m_accT[3], m_dt[3], m_dT[3], m_oft[3], m_ofT[3];

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            m_acct[m] = 0; m_accT[m] = 0; m_dt[m] = 0;
            m_dT[m] = 0; m_oft[m] = 0; m_ofT[m] = 0;
        end
    endtask

    task automatic model_clear(input int m);
        m_acct[m] = 0; m_dt[m] = 0; m_oft[m] = 0;
    endtask

    task automatic model_rev(input int m, input int c, input int clr);
        exp_t e;
        int s;
        s = m_accT[m] + c;
        if (s >= m_unit[m]) begin
            m_accT[m] = s - m_unit[m];
            if (m_dT[m] == m_dmax[m]) begin
                m_ofT[m] = 1;
                m_dT[m]  = (m_sat[m] != 0) ? m_dmax[m] : 0;
            end else begin
                m_dT[m] = m_dT[m] + 1;
            end
        end else begin
            m_accT[m] = s;
        end
        if (clr != 0) begin
            model_clear(m);
        end else begin
            s = m_acct[m] + c;
            if (s >= m_unit[m]) begin
                m_acct[m] = s - m_unit[m];
                if (m_dt[m] == m_dmax[m]) begin
                    m_oft[m] = 1;
                    m_dt[m]  = (m_sat[m] != 0) ? m_dmax[m] : 0;
                end else begin
                    m_dt[m] = m_dt[m] + 1;
                end
            end else begin
                m_acct[m] = s;
            end
        end
        e = '{m_dt[m], m_dT[m], m_oft[m], m_ofT[m]};
        case (m)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Drive a reed level for a number of cycles, counting rev pulses seen.
    // Called and returns at a falling clock edge.
    task automatic hold(input int g, input logic lvl, input int cyc, output int n);
        n = 0;
        case (g)
            0:       reed_a = lvl;
            1:       reed_b = lvl;
            default: reed_c = lvl;
        endcase
        for (int i = 0; i < cyc; i++) begin
            @(negedge clock);
            case (g)
                0:       if (rp_a === 1'b1) n++;
                1:       if (rp_b === 1'b1) n++;
                default: if (rp_s === 1'b1) n++;
            endcase
        end
    endtask

    // One-cycle reed pulse and settle; distances are updated on return.
    task automatic rev(input int g, output int n);
        int a, b;
        hold(g, 1'b1, 1, a);
        hold(g, 1'b0, 4, b);
        n = a + b;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            reed_a = i[0];
            reed_b = i[0];
            reed_c = i[0];
            @(negedge clock);
            total++;
            if ({dt_a, dT_a, tovf_a, Tovf_a, rp_a, dt_b, dT_b, tovf_b, Tovf_b, rp_b,
                 dt_s, dT_s, tovf_s, Tovf_s, rp_s, dt_w, dT_w, tovf_w, Tovf_w, rp_w} !== '0) begin
                bad++;
                $display("FAIL reset_outputs cycle %0d: got a=%h/%h b=%h/%h s=%h/%h w=%h/%h want all 0",
                         i, dt_a, dT_a, dt_b, dT_b, dt_s, dT_s, dt_w, dT_w);
            end
        end
        reed_a = 1'b0; reed_b = 1'b0; reed_c = 1'b0;
        reset  = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            total++;
            if (rp_a !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_pulse cycle %0d: got %b want 0", i, rp_a);
            end
        end
        // reed sampled high at edge N; pulse visible only after edge N+2
        model_rev(0, 0, 0);
        reed_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            total++;
            if (rp_a !== (i == 2)) begin
                bad++;
                $display("FAIL rev_latency edge N+%0d: got %b want %b", i, rp_a, (i == 2));
            end
            if (i == 0) reed_a = 1'b0;
        end
        void'(q0.pop_front());
    endtask

    task automatic test_accumulation();
        int n;
        exp_t e;
        circ_a = 8'd255;
        for (int r = 1; r <= 40; r++) begin
            model_rev(0, 255, 0);
            rev(0, n);
            e = q0.pop_front();
            total++;
            if (n != 1 || int'(dt_a) != e.trip || int'(dT_a) != e.tot) begin
                bad++;
                $display("FAIL accum rev %0d: got pulses=%0d trip=%0d total=%0d want 1 %0d %0d",
                         r, n, dt_a, dT_a, e.trip, e.tot);
            end
            if (r == 39) begin
                total++;
                if (dt_a !== 14'd0 || dT_a !== 14'd0) begin
                    bad++;
                    $display("FAIL accum_39: got %0d/%0d want 0/0", dt_a, dT_a);
                end
            end
            if (r == 40) begin
                total++;
                if (dt_a !== 14'd1 || dT_a !== 14'd1) begin
                    bad++;
                    $display("FAIL accum_40: got %0d/%0d want 1/1", dt_a, dT_a);
                end
            end
        end
    endtask

    task automatic test_trip_clear();
        int n;
        exp_t e;
        n = 0;
        model_rev(0, 255, 1);
        reed_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (rp_a === 1'b1) n++;
            if (i == 0) reed_a = 1'b0;
            if (i == 2) begin
                total++;
                if (rp_a !== 1'b1) begin
                    bad++;
                    $display("FAIL clear_coincident: got rev_pulse=%b want 1", rp_a);
                end
                clr_a = 1'b1;
            end
            if (i == 3) clr_a = 1'b0;
        end
        e = q0.pop_front();
        total++;
        if (n != 1 || dt_a !== 14'd0 || dT_a !== 14'd1 || int'(dT_a) != e.tot) begin
            bad++;
            $display("FAIL clear_rev41: got pulses=%0d trip=%0d total=%0d want 1 0 1", n, dt_a, dT_a);
        end
        for (int r = 1; r <= 39; r++) begin
            model_rev(0, 255, 0);
            rev(0, n);
            e = q0.pop_front();
            total++;
            if (n != 1 || int'(dt_a) != e.trip || int'(dT_a) != e.tot) begin
                bad++;
                $display("FAIL clear_follow rev %0d: got trip=%0d total=%0d want %0d %0d",
                         r, dt_a, dT_a, e.trip, e.tot);
            end
        end
        total++;
        if (dt_a !== 14'd0 || dT_a !== 14'd2) begin
            bad++;
            $display("FAIL clear_final: got %0d/%0d want 0/2", dt_a, dT_a);
        end
    endtask

    task automatic test_circ_zero();
        int n, cnt;
        exp_t e;
        cnt = 0;
        circ_a = 8'd0;
        for (int r = 0; r < 10; r++) begin
            model_rev(0, 0, 0);
            rev(0, n);
            cnt += n;
            e = q0.pop_front();
            total++;
            if (int'(dt_a) != e.trip || int'(dT_a) != e.tot) begin
                bad++;
                $display("FAIL circ0 rev %0d: got %0d/%0d want %0d/%0d", r, dt_a, dT_a, e.trip, e.tot);
            end
        end
        total++;
        if (cnt != 10) begin
            bad++;
            $display("FAIL circ0_pulses: got %0d want 10", cnt);
        end
        // remainders untouched: trip 9945 cm + 255 crosses a unit, total 400 + 255 does not
        circ_a = 8'd255;
        model_rev(0, 255, 0);
        rev(0, n);
        e = q0.pop_front();
        total++;
        if (dt_a !== 14'd1 || dT_a !== 14'd2 || int'(dt_a) != e.trip) begin
            bad++;
            $display("FAIL circ0_acc_kept: got %0d/%0d want 1/2", dt_a, dT_a);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic prev;
        exp_t e;
        n = 0;
        prev = 1'b0;
        circ_a = 8'd255;
        for (int c = 0; c < 26; c++) begin
            reed_a = (c < 18) && (c % 3 == 0);
            if (reed_a) model_rev(0, 255, 0);
            @(negedge clock);
            if (prev && q0.size() > 0) begin
                e = q0.pop_front();
                total++;
                if (int'(dt_a) != e.trip || int'(dT_a) != e.tot) begin
                    bad++;
                    $display("FAIL b2b cycle %0d: got %0d/%0d want %0d/%0d", c, dt_a, dT_a, e.trip, e.tot);
                end
            end
            if (rp_a === 1'b1) n++;
            prev = rp_a;
        end
        reed_a = 1'b0;
        total++;
        if (n != 6 || q0.size() != 0) begin
            bad++;
            $display("FAIL b2b_pulses: got %0d (left %0d) want 6 (left 0)", n, q0.size());
        end
    endtask

    task automatic test_debounce();
        int a, b;
        circ_b = 8'd0;
        hold(1, 1'b0, 4, a);
        hold(1, 1'b1, 3, a);
        hold(1, 1'b0, 10, b);
        total++;
        if (a + b != 0) begin
            bad++;
            $display("FAIL deb_short: got %0d pulses want 0", a + b);
        end
        hold(1, 1'b1, 8, a);
        total++;
        if (a != 1) begin
            bad++;
            $display("FAIL deb_long: got %0d pulses want 1", a);
        end
        hold(1, 1'b0, 3, a);
        hold(1, 1'b1, 8, b);
        total++;
        if (a + b != 0) begin
            bad++;
            $display("FAIL deb_glitch: got %0d pulses want 0", a + b);
        end
        hold(1, 1'b0, 10, a);
        hold(1, 1'b1, 6, b);
        total++;
        if (a != 0 || b != 1) begin
            bad++;
            $display("FAIL deb_second: got %0d/%0d pulses want 0/1", a, b);
        end
        hold(1, 1'b0, 10, a);
    endtask

    task automatic test_overflow();
        int n;
        exp_t es, ew;
        circ_c = 8'd199;
        for (int r = 1; r <= 18; r++) begin
            model_rev(1, 199, 0);
            model_rev(2, 199, 0);
            rev(2, n);
            es = q1.pop_front();
            ew = q2.pop_front();
            total++;
            if (n != 1 || int'(dt_s) != es.trip || int'(dT_s) != es.tot ||
                int'(tovf_s) != es.tovf || int'(Tovf_s) != es.Tovf ||
                int'(dt_w) != ew.trip || int'(dT_w) != ew.tot ||
                int'(tovf_w) != ew.tovf || int'(Tovf_w) != ew.Tovf) begin
                bad++;
                $display("FAIL ovf rev %0d: got s=%0d/%0d/%b%b w=%0d/%0d/%b%b want s=%0d/%0d/%0d%0d w=%0d/%0d/%0d%0d",
                         r, dt_s, dT_s, tovf_s, Tovf_s, dt_w, dT_w, tovf_w, Tovf_w,
                         es.trip, es.tot, es.tovf, es.Tovf, ew.trip, ew.tot, ew.tovf, ew.Tovf);
            end
            if (r == 16) begin
                total++;
                if ({dt_s, dT_s, tovf_s, Tovf_s} !== {4'd15, 4'd15, 2'b00}) begin
                    bad++;
                    $display("FAIL ovf_at_max: got %0d/%0d/%b%b want 15/15/00", dt_s, dT_s, tovf_s, Tovf_s);
                end
            end
            if (r == 17) begin
                total++;
                if ({dt_s, dT_s, tovf_s, Tovf_s, dt_w, dT_w, tovf_w, Tovf_w} !==
                    {4'd15, 4'd15, 2'b11, 4'd0, 4'd0, 2'b11}) begin
                    bad++;
                    $display("FAIL ovf_event: got s=%0d/%0d/%b%b w=%0d/%0d/%b%b want s=15/15/11 w=0/0/11",
                             dt_s, dT_s, tovf_s, Tovf_s, dt_w, dT_w, tovf_w, Tovf_w);
                end
            end
        end
        clr_c = 1'b1;
        model_clear(1);
        model_clear(2);
        @(negedge clock);
        clr_c = 1'b0;
        total++;
        if ({dt_s, tovf_s, Tovf_s, dT_s, dt_w, tovf_w, Tovf_w} !== {4'd0, 2'b01, 4'd15, 4'd0, 2'b01} ||
            int'(dT_w) != m_dT[2]) begin
            bad++;
            $display("FAIL ovf_clear: got s=%0d/%0d/%b%b w=%0d/%0d/%b%b want s=0/15/01 w=0/%0d/01",
                     dt_s, dT_s, tovf_s, Tovf_s, dt_w, dT_w, tovf_w, Tovf_w, m_dT[2]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        reed_a = 1'b0; reed_b = 1'b0; reed_c = 1'b0;
        clr_a  = 1'b0; clr_b  = 1'b0; clr_c  = 1'b0;
        circ_a = 8'd0; circ_b = 8'd0; circ_c = 8'd199;
        model_reset();
        test_reset();
        test_accumulation();
        test_trip_clear();
        test_circ_zero();
        test_back_to_back();
        test_debounce();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
